// File: rtl/video_mix_pkg.sv
// Shared constants, types and helpers for the video layer mixer.
package video_mix_pkg;

    localparam logic [3:0] C_BG_ID      = 4'd15;
    localparam int         C_MAX_LAYERS = 8;
    localparam int         C_MAX_DAT_W  = 16;

    // Widest supported component size; narrower builds use the low bits.
    typedef struct packed {
        logic [C_MAX_DAT_W-1:0] y;
        logic [C_MAX_DAT_W-1:0] u;
        logic [C_MAX_DAT_W-1:0] v;
    } yuv_t;

    function automatic logic [C_MAX_DAT_W-1:0] midscale(input int dat_w);
        return C_MAX_DAT_W'(1) << (dat_w - 1);
    endfunction

endpackage

// File: rtl/boxcar_avg.sv
// Running boxcar average over the last 2^C_LOG2 enabled samples.
module boxcar_avg #(
    parameter int C_WIDTH = 8,
    parameter int C_LOG2  = 3
) (
    input  logic               CK_i,
    input  logic               SYS_R_i,
    input  logic               EN_i,
    input  logic [C_WIDTH-1:0] D_i,
    output logic [C_WIDTH-1:0] Q_o
);

    localparam int C_LEN   = 1 << C_LOG2;
    localparam int C_SUM_W = C_WIDTH + C_LOG2;

    logic [C_WIDTH-1:0] hist [C_LEN];
    logic [C_SUM_W-1:0] sum;
    logic [C_SUM_W-1:0] sum_nx;

    // The true running sum always fits in C_SUM_W, so wrap-around here cancels out.
    assign sum_nx = sum + C_SUM_W'(D_i) - C_SUM_W'(hist[C_LEN-1]);

    always_ff @(posedge CK_i) begin
        if (SYS_R_i) begin
            for (int i = 0; i < C_LEN; i++) hist[i] <= '0;
            sum <= '0;
            Q_o <= '0;
        end else if (EN_i) begin
            hist[0] <= D_i;
            for (int i = 1; i < C_LEN; i++) hist[i] <= hist[i-1];
            sum <= sum_nx;
            Q_o <= sum_nx[C_SUM_W-1:C_LOG2];
        end
    end

endmodule

// File: rtl/video_layer_mix.sv
// Overlay mixer: prescaled pixel enable, two-stage layer select, frame counter, luma boxcar.
// Optional per-layer blinking is built with VIDEO_LAYER_MIX_BLINK_EN.
module video_layer_mix
    import video_mix_pkg::*;
#(
    parameter int C_LAYERS   = 4,
    parameter int C_DAT_W    = 8,
    parameter int C_DIV_W    = 3,
    parameter int C_AVG_LOG2 = 3
) (
    input  logic                            CK_i,
    input  logic                            SYS_R_i,
    input  logic [C_DIV_W-1:0]              DIV_i,
    output logic                            CK_EE_o,
    input  logic                            XHD_i,
    input  logic                            XVD_i,
    output logic                            XHD_o,
    output logic                            XVD_o,
    input  logic [C_DAT_W-1:0]              BG_YYs_i,
    input  logic [C_DAT_W-1:0]              BG_UUs_i,
    input  logic [C_DAT_W-1:0]              BG_VVs_i,
    input  logic [C_LAYERS-1:0]             LAYER_ON_i,
    input  logic [C_LAYERS-1:0]             LAYER_CHAR_i,
    input  logic [C_LAYERS-1:0]             LAYER_FUCHI_i,
`ifdef VIDEO_LAYER_MIX_BLINK_EN
    input  logic [C_LAYERS-1:0]             BLINK_i,
`endif
    input  logic [3*C_LAYERS*C_DAT_W-1:0]   LAYER_YUVs_i,
    input  logic                            FUCHI_MASK_i,
    output logic [C_DAT_W-1:0]              YYs_o,
    output logic [C_DAT_W-1:0]              UUs_o,
    output logic [C_DAT_W-1:0]              VVs_o,
    output logic [3:0]                      LAYER_IDs_o,
    output logic [C_DAT_W-1:0]              YYs_DD_o,
    output logic [7:0]                      FCTRs_o
);

    logic [C_DIV_W-1:0]            div_cnt;
    logic [C_DAT_W-1:0]            s1_bg_y, s1_bg_u, s1_bg_v;
    logic [C_LAYERS-1:0]           s1_on, s1_char, s1_fuchi;
    logic [3*C_LAYERS*C_DAT_W-1:0] s1_yuv;
    logic                          s1_mask, s1_xhd, s1_xvd;
`ifdef VIDEO_LAYER_MIX_BLINK_EN
    logic [C_LAYERS-1:0]           s1_blink;
`endif
    logic [C_LAYERS-1:0]           on_eff;
    logic [C_DAT_W-1:0]            mix_y, mix_u, mix_v;
    logic [3:0]                    mix_id;
    logic                          hit_char, hit_fuchi;

    always_ff @(posedge CK_i) begin
        if (SYS_R_i) begin
            div_cnt <= '0;
            CK_EE_o <= 1'b0;
        end else if (div_cnt >= DIV_i) begin
            div_cnt <= '0;
            CK_EE_o <= 1'b1;
        end else begin
            div_cnt <= div_cnt + C_DIV_W'(1);
            CK_EE_o <= 1'b0;
        end
    end

    // Glyph pixels of any layer win over outlines of any layer; lowest index wins within a class.
    always_comb begin
        on_eff    = s1_on;
`ifdef VIDEO_LAYER_MIX_BLINK_EN
        on_eff    = s1_on & ~(s1_blink & {C_LAYERS{FCTRs_o[4]}});
`endif
        mix_y     = s1_bg_y;
        mix_u     = s1_bg_u;
        mix_v     = s1_bg_v;
        mix_id    = C_BG_ID;
        hit_char  = 1'b0;
        hit_fuchi = 1'b0;
        for (int i = 0; i < C_LAYERS; i++) begin
            if (!hit_char && on_eff[i] && s1_char[i]) begin
                hit_char = 1'b1;
                mix_y    = s1_yuv[3*C_DAT_W*i + 2*C_DAT_W +: C_DAT_W];
                mix_u    = s1_yuv[3*C_DAT_W*i + C_DAT_W +: C_DAT_W];
                mix_v    = s1_yuv[3*C_DAT_W*i +: C_DAT_W];
                mix_id   = 4'(i);
            end
        end
        for (int i = 0; i < C_LAYERS; i++) begin
            if (!hit_char && !hit_fuchi && on_eff[i] && s1_fuchi[i] && !s1_mask) begin
                hit_fuchi = 1'b1;
                mix_y     = '0;
                mix_u     = C_DAT_W'(midscale(C_DAT_W));
                mix_v     = C_DAT_W'(midscale(C_DAT_W));
                mix_id    = 4'(i);
            end
        end
    end

    always_ff @(posedge CK_i) begin
        if (SYS_R_i) begin
            s1_bg_y     <= '0;
            s1_bg_u     <= '0;
            s1_bg_v     <= '0;
            s1_on       <= '0;
            s1_char     <= '0;
            s1_fuchi    <= '0;
            s1_yuv      <= '0;
            s1_mask     <= 1'b0;
            s1_xhd      <= 1'b1;
            s1_xvd      <= 1'b1;
`ifdef VIDEO_LAYER_MIX_BLINK_EN
            s1_blink    <= '0;
`endif
            YYs_o       <= '0;
            UUs_o       <= '0;
            VVs_o       <= '0;
            LAYER_IDs_o <= C_BG_ID;
            XHD_o       <= 1'b1;
            XVD_o       <= 1'b1;
            FCTRs_o     <= '0;
        end else if (CK_EE_o) begin
            s1_bg_y     <= BG_YYs_i;
            s1_bg_u     <= BG_UUs_i;
            s1_bg_v     <= BG_VVs_i;
            s1_on       <= LAYER_ON_i;
            s1_char     <= LAYER_CHAR_i;
            s1_fuchi    <= LAYER_FUCHI_i;
            s1_yuv      <= LAYER_YUVs_i;
            s1_mask     <= FUCHI_MASK_i;
            s1_xhd      <= XHD_i;
            s1_xvd      <= XVD_i;
`ifdef VIDEO_LAYER_MIX_BLINK_EN
            s1_blink    <= BLINK_i;
`endif
            if (s1_xvd && !XVD_i) FCTRs_o <= FCTRs_o + 8'd1;
            YYs_o       <= mix_y;
            UUs_o       <= mix_u;
            VVs_o       <= mix_v;
            LAYER_IDs_o <= mix_id;
            XHD_o       <= s1_xhd;
            XVD_o       <= s1_xvd;
        end
    end

    boxcar_avg #(
        .C_WIDTH (C_DAT_W),
        .C_LOG2  (C_AVG_LOG2)
    ) u_boxcar (
        .CK_i    (CK_i),
        .SYS_R_i (SYS_R_i),
        .EN_i    (CK_EE_o),
        .D_i     (YYs_o),
        .Q_o     (YYs_DD_o)
    );

endmodule

// File: tb/tb_video_layer_mix.sv
// Self-checking bench for video_layer_mix: directed pins plus randomized traffic against a reference model.
module tb_video_layer_mix;
    import video_mix_pkg::*;

    localparam int L  = 4;
    localparam int W  = 8;
    localparam int DW = 3;
    localparam int AL = 3;
    localparam int N  = 1 << AL;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst = 1'b1;
    logic [DW-1:0]     div = 3'd3;
    logic              ce;
    logic              xhd_i = 1'b1, xvd_i = 1'b1, xhd_o, xvd_o;
    logic [W-1:0]      bg_y = '0, bg_u = '0, bg_v = '0;
    logic [L-1:0]      on = '0, chr = '0, fuchi = '0;
    logic [3*L*W-1:0]  yuv = '0;
    logic              mask = 1'b0;
    logic [W-1:0]      y_o, u_o, v_o, dd_o;
    logic [3:0]        id_o;
    logic [7:0]        fctr_o;

    video_layer_mix #(.C_LAYERS(L), .C_DAT_W(W), .C_DIV_W(DW), .C_AVG_LOG2(AL)) dut (
        .CK_i(clk), .SYS_R_i(rst), .DIV_i(div), .CK_EE_o(ce),
        .XHD_i(xhd_i), .XVD_i(xvd_i), .XHD_o(xhd_o), .XVD_o(xvd_o),
        .BG_YYs_i(bg_y), .BG_UUs_i(bg_u), .BG_VVs_i(bg_v),
        .LAYER_ON_i(on), .LAYER_CHAR_i(chr), .LAYER_FUCHI_i(fuchi),
        .LAYER_YUVs_i(yuv), .FUCHI_MASK_i(mask),
        .YYs_o(y_o), .UUs_o(u_o), .VVs_o(v_o), .LAYER_IDs_o(id_o),
        .YYs_DD_o(dd_o), .FCTRs_o(fctr_o)
    );

    typedef struct {
        yuv_t       c;
        logic [3:0] id;
        logic       hd;
        logic       vd;
    } exp_t;

    exp_t q[$];
    int   yhist[$];
    int   m_cnt, m_fctr, m_dd, s;
    bit   m_ee, last_vd, armed;
    exp_t e_prev, e_cur;
    int   checks = 0, errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic exp_t reset_exp();
        exp_t r;
        r.c  = '0;
        r.id = 4'd15;
        r.hd = 1'b1;
        r.vd = 1'b1;
        return r;
    endfunction

    function automatic exp_t cur_exp();
        if (q.size() >= 2) return q[q.size()-2];
        return reset_exp();
    endfunction

    // Outline pass first, glyph pass second, each scanned high-to-low so the lowest index lands last.
    function automatic exp_t mix_now();
        exp_t r;
        r.hd   = xhd_i;
        r.vd   = xvd_i;
        r.c.y  = 16'(bg_y);
        r.c.u  = 16'(bg_u);
        r.c.v  = 16'(bg_v);
        r.id   = 4'd15;
        for (int i = L-1; i >= 0; i--)
            if (on[i] && fuchi[i] && !mask) begin
                r.c.y = 16'h0;
                r.c.u = 16'h80;
                r.c.v = 16'h80;
                r.id  = 4'(i);
            end
        for (int i = L-1; i >= 0; i--)
            if (on[i] && chr[i]) begin
                r.c.y = 16'(yuv[3*W*i + 2*W +: W]);
                r.c.u = 16'(yuv[3*W*i + W +: W]);
                r.c.v = 16'(yuv[3*W*i +: W]);
                r.id  = 4'(i);
            end
        return r;
    endfunction

    always @(posedge clk) begin
        #1;
        if (rst) begin
            m_cnt = 0; m_ee = 1'b0; m_fctr = 0; m_dd = 0; last_vd = 1'b1;
            q.delete();
            yhist.delete();
            armed = 1'b1;
        end else begin
            if (m_ee) begin
                e_prev = cur_exp();
                yhist.push_back(int'(e_prev.c.y));
                if (yhist.size() > N) void'(yhist.pop_front());
                s = 0;
                foreach (yhist[k]) s += yhist[k];
                m_dd = s / N;
                q.push_back(mix_now());
                if (q.size() > 2) void'(q.pop_front());
                if (last_vd && !xvd_i) m_fctr = (m_fctr + 1) % 256;
                last_vd = xvd_i;
            end
            if (m_cnt >= int'(div)) begin
                m_cnt = 0;
                m_ee  = 1'b1;
            end else begin
                m_cnt++;
                m_ee = 1'b0;
            end
        end
        if (armed) begin
            e_cur = cur_exp();
            chk("m_ck_ee", 32'(ce),     32'(m_ee));
            chk("m_y",     32'(y_o),    32'(e_cur.c.y));
            chk("m_u",     32'(u_o),    32'(e_cur.c.u));
            chk("m_v",     32'(v_o),    32'(e_cur.c.v));
            chk("m_id",    32'(id_o),   32'(e_cur.id));
            chk("m_xhd",   32'(xhd_o),  32'(e_cur.hd));
            chk("m_xvd",   32'(xvd_o),  32'(e_cur.vd));
            chk("m_dd",    32'(dd_o),   32'(m_dd));
            chk("m_fctr",  32'(fctr_o), 32'(m_fctr));
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_layer(input int i, input logic [W-1:0] y, input logic [W-1:0] u, input logic [W-1:0] v);
        yuv[3*W*i +: 3*W] = {y, u, v};
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_ce"},   32'(ce),     32'h0);
        chk({tag, "_y"},    32'(y_o),    32'h0);
        chk({tag, "_u"},    32'(u_o),    32'h0);
        chk({tag, "_v"},    32'(v_o),    32'h0);
        chk({tag, "_id"},   32'(id_o),   32'hF);
        chk({tag, "_xhd"},  32'(xhd_o),  32'h1);
        chk({tag, "_xvd"},  32'(xvd_o),  32'h1);
        chk({tag, "_fctr"}, 32'(fctr_o), 32'h0);
        chk({tag, "_dd"},   32'(dd_o),   32'h0);
    endtask

    logic [7:0] dd_tab [8] = '{8'h1F, 8'h3F, 8'h5F, 8'h7F, 8'h9F, 8'hBF, 8'hDF, 8'hFF};

    initial begin
        tick(3);
        chk_reset_vals("reset");
        rst = 1'b0;

        // Prescaler cadence with terminal count 3, then lowering it past the count.
        for (int k = 1; k <= 14; k++) begin
            tick(1);
            chk("div3_ce", 32'(ce), 32'((k % 4) == 0));
        end
        div = 3'd1;
        tick(1);
        chk("div_lower_ce", 32'(ce), 32'h1);

        div = 3'd0;
        set_layer(0, 8'h11, 8'h12, 8'h13);
        set_layer(1, 8'h51, 8'h52, 8'h53);
        set_layer(2, 8'h61, 8'h62, 8'h63);
        set_layer(3, 8'h71, 8'h72, 8'h73);
        on = 4'b0111; chr = 4'b0110; fuchi = 4'b0001;
        tick(4);
        chk("char_y",  32'(y_o),  32'h51);
        chk("char_u",  32'(u_o),  32'h52);
        chk("char_v",  32'(v_o),  32'h53);
        chk("char_id", 32'(id_o), 32'h1);

        bg_y = 8'h10; bg_u = 8'h20; bg_v = 8'h30;
        on = 4'b1000; chr = 4'b0000; fuchi = 4'b1000; mask = 1'b0;
        tick(1);
        chk("latency_id_hold", 32'(id_o), 32'h1);
        tick(1);
        chk("fuchi_y",  32'(y_o),  32'h00);
        chk("fuchi_u",  32'(u_o),  32'h80);
        chk("fuchi_v",  32'(v_o),  32'h80);
        chk("fuchi_id", 32'(id_o), 32'h3);
        mask = 1'b1;
        tick(2);
        chk("masked_y",  32'(y_o),  32'h10);
        chk("masked_u",  32'(u_o),  32'h20);
        chk("masked_v",  32'(v_o),  32'h30);
        chk("masked_id", 32'(id_o), 32'hF);

        // Luma step response through the 8-tap boxcar.
        on = '0; bg_y = 8'h00;
        tick(12);
        chk("boxcar_zero", 32'(dd_o), 32'h0);
        bg_y = 8'hFF;
        for (int t = 0; t < 10 && y_o !== 8'hFF; t++) tick(1);
        chk("step_seen", 32'(y_o), 32'hFF);
        for (int k = 0; k < 8; k++) begin
            tick(1);
            chk("boxcar_step", 32'(dd_o), 32'(dd_tab[k]));
        end

        chk("fctr_start", 32'(fctr_o), 32'h0);
        for (int p = 0; p < 255; p++) begin
            xvd_i = 1'b0; tick(1);
            xvd_i = 1'b1; tick(1);
        end
        tick(2);
        chk("fctr_255", 32'(fctr_o), 32'hFF);
        xvd_i = 1'b0; tick(1);
        xvd_i = 1'b1; tick(2);
        chk("fctr_wrap", 32'(fctr_o), 32'h0);

        // Reset in the middle of a frame while the pixel enable is running.
        for (int p = 0; p < 3; p++) begin
            xvd_i = 1'b0; tick(1);
            xvd_i = 1'b1; tick(1);
        end
        on = 4'b0100; chr = 4'b0100; xhd_i = 1'b0; xvd_i = 1'b0;
        tick(4);
        chk("pre_rst_fctr", 32'(fctr_o), 32'h4);
        chk("pre_rst_y",    32'(y_o),    32'h61);
        rst = 1'b1;
        tick(1);
        chk_reset_vals("midrst");
        rst = 1'b0; xhd_i = 1'b1; xvd_i = 1'b1;

        for (int seg = 0; seg < 40; seg++) begin
            div = 3'($urandom_range(0, 4));
            for (int t = 0; t < 50; t++) begin
                on    = 4'($urandom);
                chr   = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom);
                fuchi = 4'($urandom);
                for (int i = 0; i < 3*L; i++) yuv[W*i +: W] = 8'($urandom);
                bg_y  = 8'($urandom);
                bg_u  = 8'($urandom);
                bg_v  = 8'($urandom);
                mask  = ($urandom_range(0, 3) == 0);
                xhd_i = ($urandom_range(0, 5) != 0);
                xvd_i = ($urandom_range(0, 7) != 0);
                rst   = ($urandom_range(0, 199) == 0);
                tick(1);
            end
        end
        rst = 1'b0;
        tick(5);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, %0d checks, %0d errors", checks, errors);
        $fatal(1);
    end

endmodule

// File: doc/video_layer_mix.md
VIDEO_LAYER_MIX -- requirements
Module: video_layer_mix

Interface
REQ-001 SHALL have parameter C_LAYERS, default 4, number of overlay layers (legal 1..8).
REQ-002 SHALL have parameter C_DAT_W, default 8, width of each Y/U/V component.
REQ-003 SHALL have parameter C_DIV_W, default 3, prescaler divide-count width.
REQ-004 SHALL have parameter C_AVG_LOG2, default 3, log2 of boxcar length on luma (legal 0..4).
REQ-005 SHALL have ports: CK_i  in  1  sole clock; SYS_R_i  in  1  reset, synchronous, active-high.
REQ-006 SHALL have ports: DIV_i  in  C_DIV_W  prescaler terminal count; CK_EE_o  out  1  pixel enable.
REQ-007 SHALL have ports: XHD_i, XVD_i  in  1 each  active-low sync strobes; XHD_o, XVD_o  out  1 each  aligned copies.
REQ-008 SHALL have ports: BG_YYs_i, BG_UUs_i, BG_VVs_i  in  C_DAT_W each  background pixel, offset-binary chroma.
REQ-009 SHALL have ports: LAYER_ON_i, LAYER_CHAR_i, LAYER_FUCHI_i  in  C_LAYERS each  per-layer enable, glyph pixel, outline pixel.
REQ-010 SHALL have ports: LAYER_YUVs_i  in  3*C_LAYERS*C_DAT_W  per-layer glyph colour {Y,U,V}, layer 0 in LSBs; FUCHI_MASK_i  in  1  suppresses outlines.
REQ-011 SHALL have ports: YYs_o, UUs_o, VVs_o  out  C_DAT_W each; LAYER_IDs_o  out  4  winning layer, 15 = background.
REQ-012 SHALL have ports: YYs_DD_o  out  C_DAT_W  boxcar luma; FCTRs_o  out  8  frame counter.

Function
REQ-013 Prescaler counter SHALL increment each CK_i; when counter >= DIV_i it SHALL reset to 0 and CK_EE_o SHALL be 1 for that one clock; DIV_i=0 gives CK_EE_o constantly 1; lowering DIV_i mid-count below counter gives a pulse next clock.
REQ-014 All stages below SHALL advance only on clocks with CK_EE_o=1 and hold otherwise.
REQ-015 Stage 1 SHALL register all pixel, layer and sync inputs.
REQ-016 Stage 2 SHALL select: lowest-index layer with ON&CHAR -> its colour; else lowest-index layer with ON&FUCHI&~FUCHI_MASK_i -> Y=0, U=V=2^(C_DAT_W-1); else background.
REQ-017 Any layer's CHAR SHALL beat any layer's FUCHI regardless of index.
REQ-018 Pixel, LAYER_IDs_o, XHD_o, XVD_o latency SHALL be exactly 2 CK_EE pulses.
REQ-019 FCTRs_o SHALL increment on stage-1 XVD 1->0 transition, wrapping 255->0.
REQ-020 YYs_DD_o SHALL be floor(sum of last 2^C_AVG_LOG2 YYs_o values / 2^C_AVG_LOG2), running sum width C_DAT_W+C_AVG_LOG2, one further CK_EE latency; C_AVG_LOG2=0 gives YYs_o delayed one CK_EE.

Reset
REQ-021 On SYS_R_i=1 at a CK_i edge: prescaler 0, CK_EE_o 0, pixel outputs 0, LAYER_IDs_o 15, XHD_o=XVD_o=1, FCTRs_o 0, boxcar history and sum 0.
REQ-022 Reset SHALL override CK_EE; after release first CK_EE_o SHALL occur DIV_i+1 clocks later.

Configuration
REQ-023 With VIDEO_LAYER_MIX_BLINK_EN defined: input BLINK_i (C_LAYERS) SHALL exist; a layer with BLINK set SHALL be treated as ON=0 while FCTRs_o[4]=1.
REQ-024 Without VIDEO_LAYER_MIX_BLINK_EN: no BLINK_i port; behaviour per REQ-016 only.

Structure
REQ-025 Package video_mix_pkg SHALL hold C_BG_ID (15), max layer count (8), midscale function, YUV triplet typedef.
REQ-026 Boxcar SHALL be sub-module boxcar_avg (params width, log2 length; ports CK_i, SYS_R_i, EN_i, D_i, Q_o).

Verification
REQ-027 DIV_i=3 after reset -> CK_EE_o high on clocks 4,8,12; DIV_i 3->1 at counter 2 -> pulse next clock.
REQ-028 Layers 1,2 ON&CHAR, layer 0 ON&FUCHI -> layer 1 colour, LAYER_IDs_o=1 two CK_EE later.
REQ-029 Only layer 3 FUCHI, FUCHI_MASK_i 0 then 1 -> Y=0,U=V=0x80 then background, ID 3 then 15.
REQ-030 C_AVG_LOG2=3, YYs_o step 0->0xFF -> YYs_DD_o 0x1F,0x3F,...,0xFF over 8 CK_EE.
REQ-031 256 XVD_i low pulses -> FCTRs_o wraps to 0; BLINK_EN build: blinking layer absent frames 16-31.
REQ-032 SYS_R_i asserted mid-frame with CK_EE active -> all outputs at REQ-021 values next clock.
